// File: rtl/jtag_emu_engine.sv
// Bit-bang JTAG sequencer: shifts up to 32 TMS/TDI pairs to the debug TAP at a
// programmable TCK rate and returns the captured TDO bits as one response word.
module jtag_emu_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_trst_i,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_tms_i,
  input  logic [31:0] cmd_tdi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        busy_o,
  output logic        tck_o,
  output logic        trstn_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRST,
    SHIFT_LO,
    SHIFT_HI,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] halfCnt_q, halfCnt_d;
  logic [5:0]    bitCnt_q, bitCnt_d;
  logic [5:0]    effLen_q, effLen_d;
  logic [31:0]   tmsSh_q, tmsSh_d;
  logic [31:0]   tdiSh_q, tdiSh_d;
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          trstn_q, trstn_d;
  logic          cmdReady_q, cmdReady_d;
  logic          rspValid_q, rspValid_d;
  logic [31:0]   rspTdo_q, rspTdo_d;
  logic          busy_q, busy_d;

  logic          halfDone;
  logic [CW-1:0] halfNext;
  logic [5:0]    lenSat;

  assign halfDone = (halfCnt_q == HALF_MAX);
  assign halfNext = halfDone ? '0 : halfCnt_q + CW'(1);
  assign lenSat   = (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;

  always_comb begin
    state_d    = state_q;
    halfCnt_d  = halfCnt_q;
    bitCnt_d   = bitCnt_q;
    effLen_d   = effLen_q;
    tmsSh_d    = tmsSh_q;
    tdiSh_d    = tdiSh_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    trstn_d    = trstn_q;
    cmdReady_d = cmdReady_q;
    rspValid_d = rspValid_q;
    rspTdo_d   = rspTdo_q;

    case (state_q)
      IDLE: begin
        tck_d      = 1'b0;
        trstn_d    = 1'b1;
        cmdReady_d = 1'b1;
        if (cmd_valid_i && cmdReady_q) begin
          cmdReady_d = 1'b0;
          rspTdo_d   = '0;
          halfCnt_d  = '0;
          bitCnt_d   = '0;
          if (cmd_trst_i) begin
            state_d = TRST;
            trstn_d = 1'b0;
          end else if (lenSat == 6'd0) begin
            state_d    = RESP;
            rspValid_d = 1'b1;
          end else begin
            // Bit 0 goes straight to the pins; the rest wait in the shifters.
            state_d  = SHIFT_LO;
            effLen_d = lenSat;
            tms_d    = cmd_tms_i[0];
            tdi_d    = cmd_tdi_i[0];
            tmsSh_d  = cmd_tms_i >> 1;
            tdiSh_d  = cmd_tdi_i >> 1;
          end
        end
      end

      TRST: begin
        // bitCnt_q[0] marks the second half-period of the reset pulse.
        halfCnt_d = halfNext;
        if (halfDone) begin
          if (bitCnt_q[0]) begin
            state_d    = RESP;
            trstn_d    = 1'b1;
            rspValid_d = 1'b1;
          end else begin
            bitCnt_d = 6'd1;
          end
        end
      end

      SHIFT_LO: begin
        halfCnt_d = halfNext;
        if (halfDone) begin
          state_d                 = SHIFT_HI;
          tck_d                   = 1'b1;
          rspTdo_d[bitCnt_q[4:0]] = tdo_i;
        end
      end

      SHIFT_HI: begin
        halfCnt_d = halfNext;
        if (halfDone) begin
          tck_d = 1'b0;
          if (bitCnt_q == effLen_q - 6'd1) begin
            state_d    = RESP;
            rspValid_d = 1'b1;
          end else begin
            state_d  = SHIFT_LO;
            bitCnt_d = bitCnt_q + 6'd1;
            tms_d    = tmsSh_q[0];
            tdi_d    = tdiSh_q[0];
            tmsSh_d  = tmsSh_q >> 1;
            tdiSh_d  = tdiSh_q >> 1;
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d    = IDLE;
          rspValid_d = 1'b0;
          cmdReady_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      halfCnt_q  <= '0;
      bitCnt_q   <= '0;
      effLen_q   <= '0;
      tmsSh_q    <= '0;
      tdiSh_q    <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      trstn_q    <= 1'b0;
      cmdReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspTdo_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      halfCnt_q  <= halfCnt_d;
      bitCnt_q   <= bitCnt_d;
      effLen_q   <= effLen_d;
      tmsSh_q    <= tmsSh_d;
      tdiSh_q    <= tdiSh_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      trstn_q    <= trstn_d;
      cmdReady_q <= cmdReady_d;
      rspValid_q <= rspValid_d;
      rspTdo_q   <= rspTdo_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready_o = cmdReady_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_tdo_o   = rspTdo_q;
  assign busy_o      = busy_q;
  assign tck_o       = tck_q;
  assign trstn_o     = trstn_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_emu_engine.sv
// Directed bench for jtag_emu_engine: two instances (CLK_DIV 4 and 1), each
// driving a TAP state model and a TDI->TDO loopback register.
module tb_jtag_emu_engine;

  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
                         SHDR = 4'd4, EX1DR = 4'd5, PSDR = 4'd6, EX2DR = 4'd7,
                         UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                         EX1IR = 4'd12, PSIR = 4'd13, EX2IR = 4'd14, UPIR = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        selB = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdTrst = 1'b0;
  logic        rspReady = 1'b0;
  logic [5:0]  cmdLen = '0;
  logic [31:0] cmdTms = '0;
  logic [31:0] cmdTdi = '0;

  logic        cmdValidA, rspReadyA, cmdReadyA, rspValidA, busyA, tckA, trstnA, tmsA, tdiA;
  logic        cmdValidB, rspReadyB, cmdReadyB, rspValidB, busyB, tckB, trstnB, tmsB, tdiB;
  logic [31:0] rspTdoA, rspTdoB;
  logic        loopA = 1'b0;
  logic        loopB = 1'b0;
  logic [3:0]  tapA = TLR;
  logic [3:0]  tapB = TLR;

  logic        cmdReadyS, rspValidS, busyS, tckS, trstnS, tmsS, tdiS;
  logic [31:0] rspTdoS;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  assign cmdValidA = cmdValid & ~selB;
  assign cmdValidB = cmdValid & selB;
  assign rspReadyA = rspReady & ~selB;
  assign rspReadyB = rspReady & selB;

  assign cmdReadyS = selB ? cmdReadyB : cmdReadyA;
  assign rspValidS = selB ? rspValidB : rspValidA;
  assign busyS     = selB ? busyB : busyA;
  assign tckS      = selB ? tckB : tckA;
  assign trstnS    = selB ? trstnB : trstnA;
  assign tmsS      = selB ? tmsB : tmsA;
  assign tdiS      = selB ? tdiB : tdiA;
  assign rspTdoS   = selB ? rspTdoB : rspTdoA;

  jtag_emu_engine #(.CLK_DIV(4)) dutA (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmdValidA), .cmd_ready_o(cmdReadyA), .cmd_trst_i(cmdTrst),
    .cmd_len_i(cmdLen), .cmd_tms_i(cmdTms), .cmd_tdi_i(cmdTdi),
    .rsp_valid_o(rspValidA), .rsp_ready_i(rspReadyA), .rsp_tdo_o(rspTdoA),
    .busy_o(busyA), .tck_o(tckA), .trstn_o(trstnA), .tms_o(tmsA),
    .tdi_o(tdiA), .tdo_i(loopA)
  );

  jtag_emu_engine #(.CLK_DIV(1)) dutB (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmdValidB), .cmd_ready_o(cmdReadyB), .cmd_trst_i(cmdTrst),
    .cmd_len_i(cmdLen), .cmd_tms_i(cmdTms), .cmd_tdi_i(cmdTdi),
    .rsp_valid_o(rspValidB), .rsp_ready_i(rspReadyB), .rsp_tdo_o(rspTdoB),
    .busy_o(busyB), .tck_o(tckB), .trstn_o(trstnB), .tms_o(tmsB),
    .tdi_o(tdiB), .tdo_i(loopB)
  );

  function automatic logic [3:0] tapNext(input logic [3:0] s, input logic t);
    case (s)
      TLR:     tapNext = t ? TLR   : RTI;
      RTI:     tapNext = t ? SELDR : RTI;
      SELDR:   tapNext = t ? SELIR : CAPDR;
      CAPDR:   tapNext = t ? EX1DR : SHDR;
      SHDR:    tapNext = t ? EX1DR : SHDR;
      EX1DR:   tapNext = t ? UPDR  : PSDR;
      PSDR:    tapNext = t ? EX2DR : PSDR;
      EX2DR:   tapNext = t ? UPDR  : SHDR;
      UPDR:    tapNext = t ? SELDR : RTI;
      SELIR:   tapNext = t ? TLR   : CAPIR;
      CAPIR:   tapNext = t ? EX1IR : SHIR;
      SHIR:    tapNext = t ? EX1IR : SHIR;
      EX1IR:   tapNext = t ? UPIR  : PSIR;
      PSIR:    tapNext = t ? EX2IR : PSIR;
      EX2IR:   tapNext = t ? UPIR  : SHIR;
      default: tapNext = t ? SELDR : RTI;
    endcase
  endfunction

  // TAP models and a one-TCK-late loopback standing in for the debug TAP.
  always @(posedge tckA or negedge trstnA)
    if (!trstnA) tapA <= TLR;
    else         tapA <= tapNext(tapA, tmsA);

  always @(posedge tckB or negedge trstnB)
    if (!trstnB) tapB <= TLR;
    else         tapB <= tapNext(tapB, tmsB);

  always @(posedge tckA) loopA <= tdiA;
  always @(posedge tckB) loopB <= tdiB;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmdReadyS && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, ":ready"}, {31'd0, cmdReadyS}, 32'd1);
  endtask

  // Issues one command and checks it cycle by cycle up to the response.
  task automatic applyStimulus(input string tag, input logic trst, input logic [5:0] len,
                               input logic [31:0] tms, input logic [31:0] tdi,
                               input int expCycle, input int expPulses, input logic [31:0] expTdo);
    int d, k, bad, firstValid, pulses;
    logic prevTck, expTck, expTrstn;
    d = selB ? 1 : 4;
    waitReady(tag);
    cmdValid = 1'b1;
    cmdTrst  = trst;
    cmdLen   = len;
    cmdTms   = tms;
    cmdTdi   = tdi;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdTrst  = ~trst;
    cmdLen   = 6'd3;
    cmdTms   = ~tms;
    cmdTdi   = ~tdi;
    bad = 0;
    firstValid = -1;
    pulses = 0;
    prevTck = 1'b0;
    for (int n = 1; n <= expCycle; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (rspValidS && firstValid < 0) firstValid = n;
      if (tckS && !prevTck) pulses++;
      prevTck = tckS;
      if (trst) begin
        expTck   = 1'b0;
        expTrstn = (n < expCycle) ? 1'b0 : 1'b1;
      end else begin
        expTck   = (n < expCycle) ? (((n - 1) / d) % 2 == 1) : 1'b0;
        expTrstn = 1'b1;
      end
      if (tckS !== expTck || trstnS !== expTrstn || busyS !== 1'b1 || cmdReadyS !== 1'b0) bad++;
      if (rspValidS !== (n == expCycle)) bad++;
      if (!trst && n < expCycle) begin
        k = (n - 1) / (2 * d);
        if (tmsS !== tms[k] || tdiS !== tdi[k]) bad++;
      end
    end
    checkOutput({tag, ":wave"}, bad, 0);
    checkOutput({tag, ":rspCycle"}, firstValid, expCycle);
    checkOutput({tag, ":pulses"}, pulses, expPulses);
    checkOutput({tag, ":rspTdo"}, rspTdoS, expTdo);
  endtask

  // Holds the response for a while, poking a new command that must be ignored.
  task automatic completeResp(input string tag, input int hold, input logic [31:0] expTdo);
    int bad;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmdValid = 1'b1;
      cmdLen   = 6'd7;
      @(posedge clk);
      #1;
      if (rspValidS !== 1'b1 || rspTdoS !== expTdo || cmdReadyS !== 1'b0) bad++;
    end
    if (hold > 0) checkOutput({tag, ":hold"}, bad, 0);
    @(negedge clk);
    cmdValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ":release"}, {29'd0, rspValidS, cmdReadyS, busyS}, 32'b010);
    @(negedge clk);
    rspReady = 1'b0;
  endtask

  initial begin
    int bad;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOuts", {25'd0, tckA, tmsA, tdiA, trstnA, cmdReadyA, rspValidA, busyA}, 32'b0100000);
    checkOutput("resetTdo", rspTdoA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("firstEdge", {29'd0, trstnA, cmdReadyA, tmsA}, 32'b111);

    selB = 1'b1;
    applyStimulus("B:toShiftDr", 1'b0, 6'd4, 32'h0000_0002, 32'h0, 9, 4, 32'h0);
    checkOutput("B:tapShdr", {28'd0, tapB}, {28'd0, SHDR});
    completeResp("B:toShiftDr", 0, 32'h0);
    applyStimulus("B:tms5", 1'b0, 6'd5, 32'h0000_001F, 32'h0, 11, 5, 32'h0);
    checkOutput("B:tapTlr", {28'd0, tapB}, {28'd0, TLR});
    completeResp("B:tms5", 0, 32'h0);

    selB = 1'b0;
    applyStimulus("A:toShiftIr", 1'b0, 6'd5, 32'h0000_0006, 32'h0, 41, 5, 32'h0);
    checkOutput("A:tapShir", {28'd0, tapA}, {28'd0, SHIR});
    completeResp("A:toShiftIr", 0, 32'h0);
    checkOutput("A:idleTms", {31'd0, tmsA}, 32'd0);
    applyStimulus("A:loop32", 1'b0, 6'd32, 32'h0, 32'hA5A5_F00F, 257, 32, 32'h4B4B_E01E);
    checkOutput("A:tapStillShir", {28'd0, tapA}, {28'd0, SHIR});
    completeResp("A:loop32", 20, 32'h4B4B_E01E);
    applyStimulus("A:len0", 1'b0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'h0);
    completeResp("A:len0", 0, 32'h0);
    applyStimulus("A:len40", 1'b0, 6'd40, 32'h0, 32'h0000_0001, 257, 32, 32'h0000_0003);
    completeResp("A:len40", 0, 32'h0000_0003);
    applyStimulus("A:trst", 1'b1, 6'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 0, 32'h0);
    checkOutput("A:tapAfterTrst", {28'd0, tapA}, {28'd0, TLR});
    completeResp("A:trst", 0, 32'h0);

    // Abort a 16-bit shift during bit 3 with an asynchronous reset.
    waitReady("A:abort");
    cmdValid = 1'b1;
    cmdTrst  = 1'b0;
    cmdLen   = 6'd16;
    cmdTms   = 32'h0;
    cmdTdi   = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    repeat (26) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("A:abortOuts", {25'd0, tckA, tmsA, tdiA, trstnA, cmdReadyA, rspValidA, busyA}, 32'b0100000);
    checkOutput("A:abortTdo", rspTdoA, 32'd0);
    checkOutput("A:abortTap", {28'd0, tapA}, {28'd0, TLR});
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rspValidA !== 1'b0 || busyA !== 1'b0) bad++;
    end
    checkOutput("A:abortNoRsp", bad, 0);
    applyStimulus("A:afterAbort", 1'b0, 6'd8, 32'h0, 32'h0000_005A, 65, 8, 32'h0000_00B5);
    completeResp("A:afterAbort", 0, 32'h0000_00B5);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/jtag_emu_engine.md
Name: jtag_emu_engine

Overview:
Bit-bang JTAG sequencer between the PS7 jtag_emu GPIO register and the PULPino debug TAP pins (tck/trstn/tms/tdi/tdo). The PS posts a command of up to 32 TMS/TDI bit pairs. The engine generates the matching TCK pulses at a programmable rate, captures TDO for each bit, and returns it as one response word. This replaces per-edge software toggling of jtag_emu_o.

Parameters:
CLK_DIV, 4, clk cycles per TCK half-period (legal range 1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command offered
cmd_ready_o  output  1  engine can accept a command
cmd_trst_i  input  1  command is a TAP reset pulse; len/tms/tdi ignored
cmd_len_i  input  6  number of bits to shift (0..32; values >32 treated as 32)
cmd_tms_i  input  32  TMS bits, bit 0 shifted first
cmd_tdi_i  input  32  TDI bits, bit 0 shifted first
rsp_valid_o  output  1  response available
rsp_ready_i  input  1  response consumed
rsp_tdo_o  output  32  captured TDO, bit k = TDO sampled for shifted bit k
busy_o  output  1  high in any state other than IDLE
tck_o  output  1  JTAG clock to TAP
trstn_o  output  1  JTAG reset to TAP, active low
tms_o  output  1  JTAG TMS to TAP
tdi_o  output  1  JTAG TDI to TAP
tdo_i  input  1  JTAG TDO from TAP

Behaviour:
- All outputs registered. Reset values: tck_o=0, tms_o=1, tdi_o=0, trstn_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_tdo_o=0, busy_o=0.
- trstn_o rises to 1 on the first clk edge after rst_n deasserts. cmd_ready_o goes to 1 on that same edge.
- Asserting rst_n mid-command aborts asynchronously. All outputs return to reset values. The command is dropped and no response is produced.
- FSM states: IDLE, TRST, SHIFT_LO, SHIFT_HI, RESP.
- IDLE: cmd_ready_o=1. Handshake is cmd_valid_i & cmd_ready_o; call that edge cycle 0. cmd_ready_o drops at cycle 1.
- IDLE -> TRST when cmd_trst_i=1.
- IDLE -> RESP when eff_len=0, with rsp_valid_o=1 at cycle 1. eff_len = min(cmd_len_i, 32).
- IDLE -> SHIFT_LO otherwise.
- TRST: trstn_o=0 and tck_o=0 for 2*CLK_DIV cycles, then go to RESP with rsp_tdo_o=0.
- SHIFT_LO for bit k: starts at cycle 1+2*k*CLK_DIV.
  - tck_o=0; tms_o=tms[k]; tdi_o=tdi[k].
  - Lasts CLK_DIV cycles.
- SHIFT_HI for bit k: starts at cycle 1+(2k+1)*CLK_DIV.
  - tck_o=1; tms_o/tdi_o unchanged.
  - rsp_tdo_o[k] captures tdo_i on the same clk edge that sets tck_o=1 (TDO is stable since the prior TCK fall).
  - Lasts CLK_DIV cycles.
- After bit eff_len-1: at cycle 1+2*eff_len*CLK_DIV, tck_o=0, rsp_valid_o=1, state=RESP. tms_o/tdi_o hold the last bit's values.
- rsp_tdo_o bits at or above eff_len are 0. rsp_tdo_o is cleared when a command is accepted.
- RESP: rsp_valid_o and rsp_tdo_o are held stable until rsp_ready_i=1. On that edge rsp_valid_o=0, state=IDLE, cmd_ready_o=1 on the next cycle. A command and a response never overlap.
- Inputs cmd_* are sampled only at the accept edge into internal shift registers. Later changes on cmd_* have no effect.
- In IDLE, tck_o=0 and tms_o/tdi_o keep their last driven values (1/0 after reset).
- Counters: half-period counter sized to hold CLK_DIV-1; bit counter 6 bits.

Test Plan:
- CLK_DIV=1, cmd len=5, tms=5'b11111, tdi=0, TAP model in reset -> exactly 5 tck_o pulses (each 1 cycle high, 1 low), rsp_valid_o at cycle 11, TAP in Test-Logic-Reset.
- CLK_DIV=4, TAP in Shift-IR, len=32, tdi=0xA5A5F00F, loopback tdo_i<=tdi one TCK later -> tck_o high/low 4 cycles each, rsp_valid_o at cycle 257, rsp_tdo_o bits match tdi delayed by one position.
- cmd_len_i=0 -> no tck_o edges, rsp_valid_o=1 at cycle 1, rsp_tdo_o=0. cmd_len_i=40 -> 32 pulses issued.
- cmd_trst_i=1, CLK_DIV=4 -> trstn_o=0 for 8 cycles, tck_o stays 0, rsp_tdo_o=0.
- rsp_ready_i held 0 for 20 cycles -> rsp_valid_o/rsp_tdo_o stable, cmd_ready_o=0, new cmd_valid_i ignored. Release -> cmd_ready_o=1 one cycle later.
- rst_n pulsed low during bit 3 of a 16-bit shift -> immediate reset values (tms_o=1, trstn_o=0), no rsp_valid_o. The next command then runs correctly.
